// File: rtl/dmem_block_responder.sv
// rtl/dmem_block_responder.sv - block data memory answering cache refill/write-back requests
module dmem_block_responder #(
   parameter int LATENCY = 5
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        read,
   input  logic        write,
   input  logic [5:0]  address,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        busywait
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [7:0] LOAD = 8'(LATENCY - 1);

   state_t      state;
   state_t      state_next;
   logic [7:0]  count;
   logic        op_write;
   logic [5:0]  addr_q;
   logic [31:0] data_q;
   logic        accept;
   logic        commit;
   logic [31:0] mem [0:63];

   always_comb begin
      state_next = state;
      busywait   = 1'b0;
      accept     = 1'b0;
      commit     = 1'b0;
      case (state)
         IDLE: begin
            // Mealy stall so the requester sees it before its first sampling edge
            busywait = read | write;
            if (read | write) begin
               accept     = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            busywait = 1'b1;
            if (count == 8'd0) begin
               commit     = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (reset) begin
         busywait = 1'b0;
         accept   = 1'b0;
         commit   = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         count    <= 8'd0;
         op_write <= 1'b0;
         addr_q   <= 6'd0;
         data_q   <= 32'd0;
         readdata <= 32'd0;
      end else begin
         state <= state_next;
         if (accept) begin
            // a simultaneous read and write is taken as a write
            op_write <= write;
            addr_q   <= address;
            data_q   <= writedata;
            count    <= LOAD;
         end else if (state == BUSY && count != 8'd0) begin
            count <= count - 8'd1;
         end
         if (commit && !op_write) begin
            readdata <= mem[addr_q];
         end
      end
   end

   // array has no reset; an aborted write never reaches it because commit is gated by reset
   always_ff @(posedge clock) begin
      if (commit && op_write) begin
         mem[addr_q] <= data_q;
      end
   end

endmodule

// File: tb/tb_dmem_block_responder.sv
// tb/tb_dmem_block_responder.sv - directed scoreboard bench for dmem_block_responder
module tb_dmem_block_responder;

   localparam int LAT = 5;

   logic        clock;
   logic        reset;
   logic        read;
   logic        write;
   logic [5:0]  address;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        busywait;

   logic        read1;
   logic        write1;
   logic [31:0] readdata1;
   logic        busywait1;

   int checks;
   int failures;

   logic [31:0] model [0:63];
   logic [31:0] exp_q [$];
   logic [31:0] exp_rd;

   dmem_block_responder #(.LATENCY(LAT)) dut (
      .clock(clock), .reset(reset), .read(read), .write(write),
      .address(address), .writedata(writedata),
      .readdata(readdata), .busywait(busywait)
   );

   dmem_block_responder #(.LATENCY(1)) dut1 (
      .clock(clock), .reset(reset), .read(read1), .write(write1),
      .address(address), .writedata(writedata),
      .readdata(readdata1), .busywait(busywait1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // one full access on the LATENCY=5 instance; drop_after>0 removes the request in that BUSY cycle
   task automatic access(input bit rd, input bit wr, input logic [5:0] a,
                         input logic [31:0] d, input int drop_after);
      @(negedge clock);
      read = rd; write = wr; address = a; writedata = d;
      if (wr) model[a] = d;
      else exp_q.push_back(model[a]);
      #1 check("busy_cycle0", 32'(busywait), 32'd1);
      for (int c = 1; c <= LAT; c++) begin
         @(negedge clock);
         if (drop_after > 0 && c == drop_after) begin
            read = 1'b0; write = 1'b0; address = 6'h00; writedata = 32'hFFFFFFFF;
         end
         #1 check("busy_cycleN", 32'(busywait), 32'd1);
      end
      @(negedge clock);
      #1 check("busy_done", 32'(busywait), 32'd0);
      if (!wr && exp_q.size() > 0) exp_rd = exp_q.pop_front();
      check("readdata_done", readdata, exp_rd);
      read = 1'b0; write = 1'b0;
   endtask

   initial begin
      checks = 0; failures = 0; exp_rd = 32'h0;
      reset = 1'b1; read = 1'b1; write = 1'b0; address = 6'h00; writedata = 32'h0;
      read1 = 1'b0; write1 = 1'b0;

      // reset held two cycles with read asserted
      repeat (2) begin
         @(negedge clock);
         #1 check("reset_busy", 32'(busywait), 32'd0);
         check("reset_readdata", readdata, 32'h0);
      end
      @(negedge clock);
      reset = 1'b0;
      #1 check("release_busy", 32'(busywait), 32'd1);
      @(negedge clock);
      reset = 1'b1; read = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      #1 check("abort_busy", 32'(busywait), 32'd0);
      check("abort_readdata", readdata, 32'h0);

      // write then read
      access(0, 1, 6'h05, 32'hDEADBEEF, 0);
      access(1, 0, 6'h05, 32'h0, 0);
      @(negedge clock);
      #1 check("readdata_hold", readdata, 32'hDEADBEEF);

      // write-back followed immediately by refill
      access(0, 1, 6'h0A, 32'h0BADF00D, 0);
      access(0, 1, 6'h12, 32'h11223344, 0);
      access(1, 0, 6'h0A, 32'h0, 0);
      access(1, 0, 6'h12, 32'h0, 0);

      // dropped request still completes at the latched address
      access(0, 1, 6'h00, 32'h00C0FFEE, 0);
      access(0, 1, 6'h3F, 32'hCAFEF00D, 2);
      access(1, 0, 6'h3F, 32'h0, 0);
      access(1, 0, 6'h00, 32'h0, 0);

      // reset in BUSY cycle 3 aborts a write
      access(0, 1, 6'h01, 32'hA5A5A5A5, 0);
      @(negedge clock);
      write = 1'b1; address = 6'h01; writedata = 32'h0;
      #1 check("rst_w_cycle0", 32'(busywait), 32'd1);
      repeat (2) begin
         @(negedge clock);
         #1 check("rst_w_busy", 32'(busywait), 32'd1);
      end
      @(negedge clock);
      reset = 1'b1; write = 1'b0;
      #1 check("rst_w_in_reset", 32'(busywait), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      #1 check("rst_w_after", 32'(busywait), 32'd0);
      exp_rd = 32'h0;
      check("rst_w_readdata", readdata, 32'h0);
      access(1, 0, 6'h01, 32'h0, 0);

      // read+write conflict performs the write and leaves readdata alone
      access(1, 1, 6'h20, 32'h12345678, 0);
      access(1, 0, 6'h20, 32'h0, 0);

      // LATENCY=1 instance: two stalled cycles
      @(negedge clock);
      write1 = 1'b1; address = 6'h07; writedata = 32'h77777777;
      #1 check("lat1_w_c0", 32'(busywait1), 32'd1);
      @(negedge clock);
      #1 check("lat1_w_c1", 32'(busywait1), 32'd1);
      @(negedge clock);
      #1 check("lat1_w_done", 32'(busywait1), 32'd0);
      write1 = 1'b0;
      @(negedge clock);
      read1 = 1'b1;
      #1 check("lat1_r_c0", 32'(busywait1), 32'd1);
      @(negedge clock);
      #1 check("lat1_r_c1", 32'(busywait1), 32'd1);
      @(negedge clock);
      #1 check("lat1_r_done", 32'(busywait1), 32'd0);
      check("lat1_readdata", readdata1, 32'h77777777);
      read1 = 1'b0;

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
